pulse_measure: RTL and testbench
================================

# pulse_measure

Measures the filtered level from the glitch-eliminator stage, which sits directly upstream. For every completed high pulse it reports the pulse width in clock cycles through a valid/ack output handshake and keeps a running count of completed pulses. Downstream logic (display, control) consumes the width through that handshake; results it does not accept in time are dropped and flagged.

## Interface
- WIDTH, 8: width of the pulse-width result and of the internal width counter
- CNT_W, 8: width of the completed-pulse counter
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- in  input  1  filtered level from the eliminator, already synchronous to clk
- ack  input  1  consumer accepts the current result while valid=1
- width  output  WIDTH  measured high-pulse width in cycles
- valid  output  1  width holds an unconsumed result
- pulses  output  CNT_W  completed high pulses since reset (wraps)
- dropped  output  1  a result was lost because valid was still pending
- ovf  output  1  present only with PULSE_MEASURE_OVF_EN; the current width saturated

## Operation
- States:
  - WAIT_LOW: entered on reset. Stay while in=1. Go to IDLE when in=0. A pulse already in progress at reset is never measured.
  - IDLE: when in=1, go to HIGH and set cnt=1.
  - HIGH:
    - When in=1, cnt increments and saturates at 2^WIDTH-1.
    - When in=0, the pulse completes: go to IDLE, pulses increments mod 2^CNT_W, then apply the result rules below.
- Result on completion:
  - If valid=0, or ack=1 in the same cycle: width is loaded with cnt, valid=1, ovf is loaded with (cnt saturated).
  - If valid=1 and ack=0: the new result is discarded. width and ovf are unchanged and dropped is set to 1.
- Handshake:
  - valid stays 1 until ack=1 is sampled.
  - width and ovf are stable while valid=1.
  - ack=1 while valid=0 is ignored.
  - When ack=1 with valid=1 and no completion in that cycle: valid=0 and dropped=0 on the next edge.
- dropped is sticky. It clears only on an accepted ack or on rst.
- pulses counts every completed pulse, including dropped ones. It is not affected by ack.
- Arithmetic: cnt is WIDTH bits, never wraps, and saturates at all-ones. pulses wraps from 2^CNT_W-1 to 0.
- WAIT_LOW is reachable only from rst. No other state can reach it.

## Timing
- Reset values: width=0, valid=0, pulses=0, dropped=0, ovf=0, cnt=0, state=WAIT_LOW.
- rst overrides everything, including in mid-pulse: all outputs return to their reset values on the next edge.
- Width definition: width equals the number of consecutive edges at which in=1 was sampled.
- Latency: if in is first sampled 0 after a pulse at edge n, then valid, width and pulses update at edge n, i.e. they are visible during the cycle after edge n.
- Back-to-back pulses: a new pulse may start in the cycle immediately after completion (in sampled 1 at edge n+1 from IDLE). There is no dead cycle.
- All outputs are registered. There are no combinational paths from in or ack to any output.

## Configuration
- PULSE_MEASURE_OVF_EN defined:
  - Port ovf and its register exist.
  - ovf=1 with a valid result whose pulse reached 2^WIDTH-1 cycles or more.
  - ovf clears together with valid.
- Undefined:
  - Port ovf and its register are absent.
  - width still saturates at 2^WIDTH-1.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, CNT_W=8.
- Single pulse: rst, in=0 for 3 cycles, then in=1 for 5 cycles, then 0 -> one edge after the fall, valid=1, width=5, pulses=1, dropped=0. Then ack=1 for 1 cycle -> valid=0 next edge, width held at 5.
- Pulse at reset: in=1 during rst and for 3 cycles after, then 0 -> no valid, pulses=0. A following 2-cycle pulse -> width=2, pulses=1.
- Unacked overlap: pulses of 3 and 4 cycles, separated by 1 low cycle, with no ack -> width=3, valid=1, dropped=1, pulses=2. Then ack -> valid=0, dropped=0.
- Simultaneous ack/completion: result width=3 pending, ack=1 exactly on the completion edge of a 4-cycle pulse -> width=4, valid stays 1, dropped=0.
- Saturation: 300-cycle pulse -> width=255, and ovf=1 when PULSE_MEASURE_OVF_EN is defined. Then an 8-cycle pulse after ack -> width=8, ovf=0.
- Mid-pulse reset: rst asserted at cycle 10 of a high pulse -> all outputs 0 next edge. in is held at 1 after rst deasserts -> no counting until in has been sampled 0.

Source files
------------

// File: rtl/pulse_measure.sv
// High-pulse width meter with valid/ack result handshake and pulse counter.
// Define PULSE_MEASURE_OVF_EN to add the ovf saturation flag port.
module pulse_measure #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             ack,
    output logic [WIDTH-1:0] width,
    output logic             valid,
    output logic [CNT_W-1:0] pulses,
`ifdef PULSE_MEASURE_OVF_EN
    output logic             ovf,
`endif
    output logic             dropped
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX = '1;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] width_n;
    logic [CNT_W-1:0] pulses_n;
    logic             valid_n;
    logic             dropped_n;
    logic             done;
`ifdef PULSE_MEASURE_OVF_EN
    logic             ovf_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOW;
            cnt     <= '0;
            width   <= '0;
            valid   <= 1'b0;
            pulses  <= '0;
            dropped <= 1'b0;
`ifdef PULSE_MEASURE_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            width   <= width_n;
            valid   <= valid_n;
            pulses  <= pulses_n;
            dropped <= dropped_n;
`ifdef PULSE_MEASURE_OVF_EN
            ovf     <= ovf_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        width_n   = width;
        valid_n   = valid;
        pulses_n  = pulses;
        dropped_n = dropped;
        done      = 1'b0;
`ifdef PULSE_MEASURE_OVF_EN
        ovf_n     = ovf;
`endif

        unique case (state)
            WAIT_LOW: begin
                if (!in) state_n = IDLE;
            end
            IDLE: begin
                if (in) begin
                    state_n = HIGH;
                    cnt_n   = {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            HIGH: begin
                if (in) begin
                    if (cnt != MAX) cnt_n = cnt + 1'b1;
                end else begin
                    state_n = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = WAIT_LOW;
        endcase

        // A completion with ack in the same cycle hands over and reloads.
        if (done) begin
            pulses_n = pulses + 1'b1;
            if (!valid || ack) begin
                width_n   = cnt;
                valid_n   = 1'b1;
                dropped_n = 1'b0;
`ifdef PULSE_MEASURE_OVF_EN
                ovf_n     = (cnt == MAX);
`endif
            end else begin
                dropped_n = 1'b1;
            end
        end else if (valid && ack) begin
            valid_n   = 1'b0;
            dropped_n = 1'b0;
`ifdef PULSE_MEASURE_OVF_EN
            ovf_n     = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pulse_measure.sv
// Scoreboard bench for pulse_measure: expected results queued at pulse end.
// Build with PULSE_MEASURE_OVF_EN to also check the ovf flag.
module tb_pulse_measure;

    typedef struct {
        logic [7:0] w;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in;
    logic       ack;
    logic [7:0] width;
    logic       valid;
    logic [7:0] pulses;
    logic       dropped;
`ifdef PULSE_MEASURE_OVF_EN
    logic       ovf;
`endif

    exp_t q[$];
    int   nchk  = 0;
    int   npass = 0;
    logic pv    = 1'b0;
    logic ack_s = 1'b0;

    pulse_measure #(.WIDTH(8), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .ack     (ack),
        .width   (width),
        .valid   (valid),
        .pulses  (pulses),
`ifdef PULSE_MEASURE_OVF_EN
        .ovf     (ovf),
`endif
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        nchk++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_once();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse(input int n, input bit keep, input bit ack_end);
        exp_t e;
        in = 1'b1;
        repeat (n) tick();
        in  = 1'b0;
        ack = ack_end;
        if (keep) begin
            e.w = (n > 255) ? 8'd255 : 8'(n);
            e.o = (n >= 255);
            q.push_back(e);
        end
        tick();
        ack = 1'b0;
    endtask

    always @(posedge clk) ack_s = ack;

    // A new result shows as valid rising, or valid held across an ack.
    always @(negedge clk) begin
        exp_t e;
        if (valid && (!pv || ack_s)) begin
            if (q.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                check("sb_width", int'(width), int'(e.w));
`ifdef PULSE_MEASURE_OVF_EN
                check("sb_ovf", int'(ovf), int'(e.o));
`endif
            end
        end
        pv = valid;
    end

    initial begin
        int n;
        int exp_p;
        rst = 1'b1;
        in  = 1'b0;
        ack = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_width", int'(width), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_pulses", int'(pulses), 0);
        check("rst_dropped", int'(dropped), 0);

        // single pulse
        repeat (3) tick();
        pulse(5, 1, 0);
        check("s1_valid", int'(valid), 1);
        check("s1_width", int'(width), 5);
        check("s1_pulses", int'(pulses), 1);
        check("s1_dropped", int'(dropped), 0);
        ack_once();
        check("s1_ack_valid", int'(valid), 0);
        check("s1_hold_width", int'(width), 5);

        // pulse already high at reset
        in  = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        in = 1'b0;
        tick();
        check("s2_valid", int'(valid), 0);
        check("s2_pulses", int'(pulses), 0);
        pulse(2, 1, 0);
        check("s2_width", int'(width), 2);
        check("s2_pulses2", int'(pulses), 1);
        ack_once();

        // unacked overlap
        pulse(3, 1, 0);
        pulse(4, 0, 0);
        check("s3_width", int'(width), 3);
        check("s3_valid", int'(valid), 1);
        check("s3_dropped", int'(dropped), 1);
        check("s3_pulses", int'(pulses), 3);
        ack_once();
        check("s3_ack_valid", int'(valid), 0);
        check("s3_ack_dropped", int'(dropped), 0);

        // ack on completion edge
        pulse(3, 1, 0);
        pulse(4, 1, 1);
        check("s4_width", int'(width), 4);
        check("s4_valid", int'(valid), 1);
        check("s4_dropped", int'(dropped), 0);
        check("s4_pulses", int'(pulses), 5);
        ack_once();

        // saturation
        pulse(300, 1, 0);
        check("s5_width", int'(width), 255);
`ifdef PULSE_MEASURE_OVF_EN
        check("s5_ovf", int'(ovf), 1);
`endif
        ack_once();
        check("s5_ack_valid", int'(valid), 0);
`ifdef PULSE_MEASURE_OVF_EN
        check("s5_ack_ovf", int'(ovf), 0);
`endif
        pulse(8, 1, 0);
        check("s5_width8", int'(width), 8);
`ifdef PULSE_MEASURE_OVF_EN
        check("s5_ovf8", int'(ovf), 0);
`endif
        check("s5_pulses", int'(pulses), 7);

        // reset in mid-pulse with a result pending
        in = 1'b1;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("s6_width", int'(width), 0);
        check("s6_valid", int'(valid), 0);
        check("s6_pulses", int'(pulses), 0);
        check("s6_dropped", int'(dropped), 0);
        rst = 1'b0;
        repeat (5) tick();
        in = 1'b0;
        tick();
        check("s6_nocount", int'(pulses), 0);
        check("s6_novalid", int'(valid), 0);
        pulse(6, 1, 0);
        check("s6_width6", int'(width), 6);
        ack_once();

        // random pulses, each acked
        exp_p = 1;
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(1, 20);
            pulse(n, 1, 0);
            exp_p++;
            ack_once();
        end
        check("rnd_pulses", int'(pulses), exp_p);

        tick();
        check("q_empty", q.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
